bcd_to_bin: RTL

Sequential converter sitting directly downstream of the keypad BCD entry stage. It takes the three latched entry digits (tens, units, tenths) and the sign flag, and produces a signed two's-complement binary value in units of tenths (−999…+999), ready for the arithmetic datapath. Conversion is an iterative multiply-by-ten/accumulate over one digit per clock, with a start/busy/done handshake and an error flag for illegal digit codes.

---
 rtl/bcd_to_bin.sv | 143 ++++++++++++++
 1 files changed

// File: rtl/bcd_to_bin.sv
// Converts three latched BCD keypad digits plus a sign flag into a signed
// two's-complement value in tenths, one digit per clock.
module bcd_to_bin #(
  parameter logic [3:0] BLANK = 4'hF,
  parameter int         OUT_W = 11
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    start,
  input  logic [3:0]              tens,
  input  logic [3:0]              units,
  input  logic [3:0]              tenths,
  input  logic                    sign_mode,
  output logic                    busy,
  output logic                    done,
  output logic                    err,
  output logic signed [OUT_W-1:0] value
);

  localparam logic [2:0] IDLE  = 3'd0;
  localparam logic [2:0] ACC_T = 3'd1;
  localparam logic [2:0] ACC_U = 3'd2;
  localparam logic [2:0] ACC_D = 3'd3;
  localparam logic [2:0] FIN   = 3'd4;
  localparam logic [2:0] ERR   = 3'd5;

  logic [2:0]              state_q, state_d;
  logic [9:0]              acc_q, acc_d;
  logic [3:0]              tens_q, tens_d;
  logic [3:0]              units_q, units_d;
  logic [3:0]              tenths_q, tenths_d;
  logic                    sign_q, sign_d;
  logic                    busy_q, busy_d;
  logic                    done_q, done_d;
  logic                    err_q, err_d;
  logic signed [OUT_W-1:0] value_q, value_d;

  logic [9:0]              acc_x10;
  logic signed [OUT_W-1:0] acc_ext;
  logic                    illegal_in;

  function automatic logic [3:0] dval(input logic [3:0] x);
    return (x == BLANK) ? 4'd0 : x;
  endfunction

  function automatic logic is_illegal(input logic [3:0] x);
    return (x >= 4'd10) && (x <= 4'd14);
  endfunction

  // acc never exceeds 99 when multiplied, so 10 bits hold the product.
  assign acc_x10    = {acc_q[6:0], 3'b000} + {acc_q[8:0], 1'b0};
  assign acc_ext    = OUT_W'(acc_q);
  assign illegal_in = is_illegal(tens) || is_illegal(units) || is_illegal(tenths);

  always_comb begin
    state_d  = state_q;
    acc_d    = acc_q;
    tens_d   = tens_q;
    units_d  = units_q;
    tenths_d = tenths_q;
    sign_d   = sign_q;
    busy_d   = busy_q;
    done_d   = 1'b0;
    err_d    = err_q;
    value_d  = value_q;
    case (state_q)
      IDLE: begin
        if (start) begin
          tens_d   = tens;
          units_d  = units;
          tenths_d = tenths;
          sign_d   = sign_mode;
          err_d    = 1'b0;
          busy_d   = 1'b1;
          acc_d    = 10'd0;
          state_d  = illegal_in ? ERR : ACC_T;
        end
      end
      ACC_T: begin
        acc_d   = {6'd0, dval(tens_q)};
        state_d = ACC_U;
      end
      ACC_U: begin
        acc_d   = acc_x10 + {6'd0, dval(units_q)};
        state_d = ACC_D;
      end
      ACC_D: begin
        acc_d   = acc_x10 + {6'd0, dval(tenths_q)};
        state_d = FIN;
      end
      FIN: begin
        // Negating a zero accumulator yields zero, so no negative zero appears.
        value_d = sign_q ? -acc_ext : acc_ext;
        done_d  = 1'b1;
        busy_d  = 1'b0;
        state_d = IDLE;
      end
      ERR: begin
        value_d = '0;
        err_d   = 1'b1;
        done_d  = 1'b1;
        busy_d  = 1'b0;
        state_d = IDLE;
      end
      default: begin
        busy_d  = 1'b0;
        state_d = IDLE;
      end
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q  <= IDLE;
      acc_q    <= 10'd0;
      tens_q   <= 4'd0;
      units_q  <= 4'd0;
      tenths_q <= 4'd0;
      sign_q   <= 1'b0;
      busy_q   <= 1'b0;
      done_q   <= 1'b0;
      err_q    <= 1'b0;
      value_q  <= '0;
    end else begin
      state_q  <= state_d;
      acc_q    <= acc_d;
      tens_q   <= tens_d;
      units_q  <= units_d;
      tenths_q <= tenths_d;
      sign_q   <= sign_d;
      busy_q   <= busy_d;
      done_q   <= done_d;
      err_q    <= err_d;
      value_q  <= value_d;
    end
  end

  assign busy  = busy_q;
  assign done  = done_q;
  assign err   = err_q;
  assign value = value_q;

endmodule
